// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: shared mode encoding and parameter helpers for the pipelined adder
package adder_pipe_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int seg_width(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic bit stages_ok(input int n, input int stages);
        return stages >= 1 && stages <= n && n % stages == 0;
    endfunction

endpackage

// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg: one W-bit segment adder with its carry and valid registers
module adder_pipe_seg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         v_in,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         v,
    output logic         c
);
    logic [W:0] t;
    logic       v_d, v_q, c_d, c_q;

    // segment sum; carry and valid are captured only when the stage advances
    always_comb begin
        t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
        v_d = en ? v_in : v_q;
        c_d = en ? t[W] : c_q;
    end

    // carry and valid registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
        end else begin
            v_q <= v_d;
            c_q <= c_d;
        end
    end

    assign sum = t[W-1:0];
    assign v   = v_q;
    assign c   = c_q;

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined add/subtract unit, one carry-chained segment per stage, valid/ready flow control
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] opea,
    input  logic [N-1:0] opeb,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sal,
    output logic         cout,
    output logic         ovf
);
    localparam int W = seg_width(N, STAGES);
    localparam int L = STAGES - 1;

    if (!stages_ok(N, STAGES)) begin : g_bad_params
        $error("adder_pipe: STAGES must divide N and lie in 1..N");
    end

    logic [STAGES:0]   rdy;
    logic [L:0]        v, c, ci, vi, sa_i, sa_d, sa_q;
    logic [L:0][W-1:0] s;
    logic [L:0][N-1:0] xi, yi, x_d, x_q, y_d, y_q;
    logic [N-1:0]      b_c;
    logic              c_c;

    // operand conditioning at accept: subtract inverts b and the borrow-in
    always_comb begin
        b_c = op_e'(sub) == OP_SUB ? ~opeb : opeb;
        c_c = op_e'(sub) == OP_SUB ? ~cin : cin;
    end

    // ready chain: a stage may load when it is empty or its successor is loading
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = L; k >= 0; k--) rdy[k] = !v[k] | rdy[k+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign xi[k]   = opea;
            assign yi[k]   = b_c;
            assign sa_i[k] = opea[N-1];
            assign ci[k]   = c_c;
            assign vi[k]   = in_valid;
        end else begin : g_body
            assign xi[k]   = x_q[k-1];
            assign yi[k]   = y_q[k-1];
            assign sa_i[k] = sa_q[k-1];
            assign ci[k]   = c[k-1];
            assign vi[k]   = v[k-1];
        end
        adder_pipe_seg #(.W(W)) u_seg (
            .clk  (clk),
            .rst  (rst),
            .en   (rdy[k]),
            .v_in (vi[k]),
            .a    (xi[k][k*W +: W]),
            .b    (yi[k][k*W +: W]),
            .c_in (ci[k]),
            .sum  (s[k]),
            .v    (v[k]),
            .c    (c[k])
        );
    end

    // skew registers: x holds finished result segments below operand-a segments still to add
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        sa_d = sa_q;
        for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
                x_d[k]             = xi[k];
                x_d[k][k*W +: W]   = s[k];
                y_d[k]             = yi[k];
                sa_d[k]            = sa_i[k];
            end
        end
    end

    // skew registers clear asynchronously alongside the stage valid and carry bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q  <= '0;
            y_q  <= '0;
            sa_q <= '0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            sa_q <= sa_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[L];
    assign sal       = x_q[L];
    assign cout      = c[L];
    assign ovf       = (sa_q[L] == y_q[L][N-1]) & (x_q[L][N-1] != sa_q[L]);

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: scoreboarded directed and random checks of adder_pipe at STAGES 4, 1, 2 and 8
module tb_adder_pipe;

    typedef struct packed {
        logic [31:0] sal;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    int   errs = 0, checks = 0, done = 0;

    always #5 clk = ~clk;

    // reference: exact integer arithmetic, unsigned for carry/borrow, signed for overflow
    function automatic res_t model(input logic [31:0] a, b, input logic c, s_);
        longint ua, ub, sa, sb, u, r;
        res_t e;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s_) begin
            u      = ua - ub - longint'(c);
            r      = sa - sb - longint'(c);
            e.cout = u >= 0;
        end else begin
            u      = ua + ub + longint'(c);
            r      = sa + sb + longint'(c);
            e.cout = u >= 64'sd4294967296;
        end
        e.sal = u[31:0];
        e.ovf = r > 64'sd2147483647 || r < -64'sd2147483648;
        return e;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_cfg
        localparam int S = i == 0 ? 4 : i == 1 ? 1 : i == 2 ? 2 : 8;

        logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, rr;
        logic [31:0] opea, opeb, sal;
        logic        held = 1'b0;
        logic [34:0] hv = '0;
        int          cyc = 0;
        res_t        q[$];
        int          pops[$];

        adder_pipe #(.N(32), .STAGES(S)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .opea      (opea),
            .opeb      (opeb),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sal       (sal),
            .cout      (cout),
            .ovf       (ovf)
        );

        task automatic chk(input string nm, input logic [63:0] act, exp);
            checks++;
            if (act !== exp) begin
                errs++;
                $display("FAIL S=%0d %s: got %0h, want %0h", S, nm, act, exp);
            end
        endtask

        task automatic send(input logic [31:0] a, b, input logic c, s_, input res_t e);
            int n = 0;
            in_valid = 1'b1;
            opea = a;
            opeb = b;
            cin = c;
            sub = s_;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 100);
            if (!in_ready) begin
                checks++;
                errs++;
                $display("FAIL S=%0d send: in_ready stuck at %0b, want 1", S, in_ready);
            end else q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        endtask

        task automatic send_rand();
            logic [31:0] a, b;
            logic        c, s_;
            logic [31:0] edge_v [4];
            edge_v = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 2) == 0) a = edge_v[$urandom_range(0, 3)];
            if ($urandom_range(0, 2) == 0) b = edge_v[$urandom_range(0, 3)];
            c  = 1'($urandom_range(0, 1));
            s_ = 1'($urandom_range(0, 1));
            send(a, b, c, s_, model(a, b, c, s_));
        endtask

        task automatic lat_chk(input string nm);
            int lat = 1;
            while (!out_valid && lat < 50) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk(nm, lat, S);
        endtask

        task automatic drain(input string nm);
            int n = 0;
            do begin
                @(posedge clk);
                n++;
            end while (q.size() != 0 && n < 300);
            #1;
            chk(nm, q.size(), 0);
        endtask

        // monitor: pop and compare on every output transfer, and check outputs hold while stalled
        always @(negedge clk) begin
            res_t e;
            cyc++;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errs++;
                    $display("FAIL S=%0d result: unexpected sal=%h, want no output", S, sal);
                end else begin
                    e = q.pop_front();
                    pops.push_back(cyc);
                    if ({sal, cout, ovf} !== e) begin
                        errs++;
                        $display("FAIL S=%0d result: got sal=%h cout=%0b ovf=%0b, want sal=%h cout=%0b ovf=%0b",
                                 S, sal, cout, ovf, e.sal, e.cout, e.ovf);
                    end
                end
            end
            if (held) begin
                checks++;
                if ({out_valid, sal, cout, ovf} !== hv) begin
                    errs++;
                    $display("FAIL S=%0d stall_hold: got %h, want %h", S, {out_valid, sal, cout, ovf}, hv);
                end
            end
            held = out_valid && !out_ready;
            hv   = {out_valid, sal, cout, ovf};
        end

        // random back-pressure while enabled
        initial forever begin
            @(posedge clk);
            #1;
            if (rr) out_ready = $urandom_range(0, 3) != 0;
        end

        initial begin
            int n;
            rst = 1'b1;
            in_valid = 1'b0;
            opea = '0;
            opeb = '0;
            cin = 1'b0;
            sub = 1'b0;
            out_ready = 1'b1;
            rr = 1'b0;
            @(posedge clk);
            #1;
            chk("reset_out_valid", out_valid, 0);
            chk("reset_sal", sal, 0);
            chk("reset_cout_ovf", {cout, ovf}, 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("reset_in_ready", in_ready, 1);

            send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, res_t'{32'h0, 1'b1, 1'b0});
            lat_chk("latency_add_wrap");
            drain("drain_t1");
            send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, res_t'{32'h8000_0000, 1'b0, 1'b1});
            send(32'h5, 32'h7, 1'b0, 1'b1, res_t'{32'hFFFF_FFFE, 1'b0, 1'b0});
            send(32'h8000_0000, 32'h1, 1'b0, 1'b1, res_t'{32'h7FFF_FFFF, 1'b1, 1'b1});
            drain("drain_t23");

            pops.delete();
            repeat (8) send_rand();
            drain("drain_b2b");
            chk("b2b_count", pops.size(), 8);
            chk("b2b_consecutive", pops[7] - pops[0], 7);

            out_ready = 1'b0;
            n = 0;
            for (int j = 0; j < 20; j++) begin
                in_valid = 1'b1;
                opea = $urandom;
                opeb = $urandom;
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (!in_ready) break;
                q.push_back(model(opea, opeb, cin, sub));
                n++;
                @(posedge clk);
                #1;
            end
            chk("stall_fill_count", n, S);
            repeat (3) @(posedge clk);
            #1;
            chk("stall_in_ready", in_ready, 0);
            out_ready = 1'b1;
            send(opea, opeb, cin, sub, model(opea, opeb, cin, sub));
            drain("drain_stall");

            repeat (3) send_rand();
            #1;
            rst = 1'b1;
            #1;
            chk("midreset_out_valid", out_valid, 0);
            chk("midreset_sal", sal, 0);
            q.delete();
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("midreset_in_ready", in_ready, 1);
            send_rand();
            lat_chk("latency_after_reset");
            drain("drain_reset");

            rr = 1'b1;
            for (int j = 0; j < 120; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_rand();
            end
            rr = 1'b0;
            out_ready = 1'b1;
            drain("drain_random");
            done++;
        end
    end

    initial begin
        int t = 0;
        while (done < 4 && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (done < 4) begin
            checks++;
            errs++;
            $display("FAIL timeout: finished configs %0d, want 4", done);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
